// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter sharing one 32:1 word mux between 32 requesters, valid/ready output.
// Define MUX32_ARB_LOCK_EN to add the lock input for multi-word bursts.

module mux32 #(
  parameter int N = 32
) (
  input  logic [4:0]      sel,
  input  logic [32*N-1:0] in_data,
  output logic [N-1:0]    out_data
);
  assign out_data = in_data[sel*N +: N];
endmodule

module mux32_rr_arbiter #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     req,
  input  logic [32*N-1:0] in_data,
`ifdef MUX32_ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [31:0]     ack,
  output logic [31:0]     grant,
  output logic [4:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data
);
  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // once out_valid rises, sel/grant/out_data hold until that transfer or an abandon.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [4:0] ptr;
  logic [4:0] base;
  logic [4:0] cand;
  logic [4:0] win_idx;
  logic       win_found;
  logic       xfer;
  logic       keep;

  assign xfer = out_valid & out_ready;
  assign ack  = grant & {32{xfer}};

`ifdef MUX32_ARB_LOCK_EN
  assign keep = xfer & lock & req[sel];
`else
  assign keep = 1'b0;
`endif

  // On a transfer the word being served becomes the new lowest priority immediately.
  always_comb begin
    base      = xfer ? sel : ptr;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      cand = base + 5'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      ptr       <= 5'd31;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            sel       <= win_idx;
            grant     <= 32'd1 << win_idx;
            out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (out_ready) begin
            if (!keep) begin
              ptr <= sel;
              if (|req) begin
                sel   <= win_idx;
                grant <= 32'd1 << win_idx;
              end else begin
                state     <= IDLE;
                grant     <= '0;
                out_valid <= 1'b0;
              end
            end
          end else if (!req[sel]) begin
            // Abandoned word: re-arbitrate from the unchanged pointer.
            if (|req) begin
              sel   <= win_idx;
              grant <= 32'd1 << win_idx;
            end else begin
              state     <= IDLE;
              grant     <= '0;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  mux32 #(.N(N)) u_mux (
    .sel      (sel),
    .in_data  (in_data),
    .out_data (out_data)
  );
endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed bench for mux32_rr_arbiter: expected grant order is queued by the stimulus
// and popped by a negedge monitor on every transfer.

module tb_mux32_rr_arbiter;
  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     req;
  logic [32*N-1:0] in_data;
  logic [31:0]     ack;
  logic [31:0]     grant;
  logic [4:0]      sel;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
`ifdef MUX32_ARB_LOCK_EN
  logic            lock;
`endif

  logic [4:0] exp_q[$];
  logic [4:0] exp_sel;
  int         vectors = 0;
  int         miscompares = 0;

  logic       probe_on = 1'b0;
  logic       probe_valid = 1'b0;
  logic [4:0] probe_sel = '0;
  logic       probe_sel_chk = 1'b0;
  logic       done = 1'b0;

  mux32_rr_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_data   (in_data),
`ifdef MUX32_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [N-1:0] word_of(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL xfer: unexpected transfer sel=%0d ack=%h", sel, ack);
      end else begin
        exp_sel = exp_q.pop_front();
        if (sel !== exp_sel || out_data !== word_of(int'(exp_sel)) ||
            ack !== (32'd1 << exp_sel) || grant !== (32'd1 << exp_sel)) begin
          miscompares++;
          $display("FAIL xfer: got sel=%0d data=%h ack=%h grant=%h, need sel=%0d data=%h ack=%h",
                   sel, out_data, ack, grant, exp_sel, word_of(int'(exp_sel)), 32'd1 << exp_sel);
        end
      end
    end else begin
      vectors++;
      if (ack !== 32'd0) begin
        miscompares++;
        $display("FAIL ack_idle: got ack=%h, need 0", ack);
      end
    end
    if (probe_on) begin
      vectors++;
      if (out_valid !== probe_valid ||
          grant !== (probe_valid ? (32'd1 << probe_sel) : 32'd0) ||
          (probe_sel_chk && sel !== probe_sel) ||
          (probe_valid && out_data !== word_of(int'(probe_sel)))) begin
        miscompares++;
        $display("FAIL state: got valid=%b sel=%0d grant=%h data=%h, need valid=%b sel=%0d",
                 out_valid, sel, grant, out_data, probe_valid, probe_sel);
      end
    end
    if (done) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d expected transfers outstanding, need 0", exp_q.size());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic v, input logic [4:0] s, input logic s_chk);
    probe_valid   = v;
    probe_sel     = s;
    probe_sel_chk = s_chk;
    probe_on      = 1'b1;
    tick();
    probe_on      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
`ifdef MUX32_ARB_LOCK_EN
    lock      = 1'b0;
`endif
    for (int i = 0; i < 32; i++) in_data[i*N +: N] = word_of(i);

    // reset state after two reset cycles
    tick();
    tick();
    probe(1'b0, 5'd0, 1'b1);
    rst = 1'b0;

    // single request, one-cycle latency
    exp_q.push_back(5'd0);
    req = 32'h1;
    out_ready = 1'b1;
    tick();
    req = '0;
    tick();
    tick();

    // all requesting: 0..31 then 0,1 with no bubble
    do_reset();
    for (int i = 0; i < 34; i++) exp_q.push_back(5'(i % 32));
    req = '1;
    out_ready = 1'b1;
    repeat (34) tick();
    req = '0;
    tick();
    tick();

    // backpressure hold on 3, then 3,30,3
    req = (32'd1 << 3) | (32'd1 << 30);
    out_ready = 1'b0;
    tick();
    repeat (5) probe(1'b1, 5'd3, 1'b1);
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd30);
    exp_q.push_back(5'd3);
    out_ready = 1'b1;
    tick();
    tick();
    req = '0;
    tick();
    tick();

    // abandon of 5 leaves ptr at 3, so 5 wins over 6 afterwards
    req = 32'd1 << 5;
    out_ready = 1'b0;
    tick();
    probe(1'b1, 5'd5, 1'b1);
    req = '0;
    tick();
    probe(1'b0, 5'd0, 1'b0);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd6);
    req = (32'd1 << 5) | (32'd1 << 6);
    out_ready = 1'b1;
    tick();
    req = 32'd1 << 6;
    tick();
    req = '0;
    tick();
    tick();

    // reset while busy on 17, then pointer back at 31
    req = 32'd1 << 17;
    out_ready = 1'b0;
    tick();
    probe(1'b1, 5'd17, 1'b1);
    rst = 1'b1;
    req = '0;
    tick();
    probe(1'b0, 5'd0, 1'b1);
    rst = 1'b0;
    exp_q.push_back(5'd0);
    exp_q.push_back(5'd17);
    req = 32'h0002_0001;
    out_ready = 1'b1;
    tick();
    req = 32'd1 << 17;
    tick();
    req = '0;
    tick();
    tick();

`ifdef MUX32_ARB_LOCK_EN
    // locked burst on 2, then 9 once lock drops
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd2);
    exp_q.push_back(5'd9);
    req = (32'd1 << 2) | (32'd1 << 9);
    lock = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    lock = 1'b0;
    req = 32'd1 << 9;
    tick();
    req = '0;
    tick();
    tick();
`endif

    // final report
    done = 1'b1;
    @(negedge clk);
    #1;
    done = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
